// File: rtl/intra_block_fetch4x4.sv
// intra_block_fetch4x4
//   Fetches one 4x4 luma block (16 original pixels) plus its reconstructed
//   top row, left column and top-left corner over a single synchronous read
//   port, then presents the packed bundle on a valid/ready handshake.
// Ports:
//   clk, reset (async, active low)
//   start, blk_row, blk_col          : request + block top-left coordinates
//   busy, start_err                  : status
//   rd_en, rd_sel, rd_addr, rd_data  : frame-memory read port (1-cycle latency)
//   out_valid, out_ready             : bundle handshake
//   orig_blk, top_row, left_col, corner, top_avail, left_avail : bundle payload
module intra_block_fetch4x4 #(
  parameter int          WIDTH  = 32,
  parameter int          LENGTH = 32,
  parameter int          ADDR_W = 16,
  parameter logic [7:0]  FILL   = 8'd128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       blk_row,
  input  logic [15:0]       blk_col,
  output logic              busy,
  output logic              start_err,
  output logic              rd_en,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      orig_blk,
  output logic [31:0]       top_row,
  output logic [31:0]       left_col,
  output logic [7:0]        corner,
  output logic              top_avail,
  output logic              left_avail
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ORIG   = 3'd1,
    TOP    = 3'd2,
    LEFT   = 3'd3,
    CORNER = 3'd4,
    DRAIN  = 3'd5,
    OUT    = 3'd6
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;      // index of the read currently on the bus
  logic [15:0] row_r, col_r;
  logic [4:0]  slot_r;                // payload slot of the read on the bus
  logic [4:0]  cap_slot_r;            // slot of the word arriving on rd_data
  logic        cap_vld_r;

  logic        issue_s, nsel_s, accept_s, reject_s, bad_s;
  logic [15:0] nrow_s, ncol_s;
  logic [4:0]  nslot_s;

  // Start validation: block must lie fully inside the frame on a 4-pixel grid
  always_comb begin
    bad_s = (blk_row > 16'(LENGTH - 4)) || (blk_col > 16'(WIDTH - 4)) ||
            (blk_row[1:0] != 2'b00) || (blk_col[1:0] != 2'b00);
  end

  // Next state and the next read to place on the bus (issued at the coming edge)
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    issue_s     = 1'b0;
    nsel_s      = 1'b0;
    nrow_s      = row_r;
    ncol_s      = col_r;
    nslot_s     = 5'd0;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && bad_s) begin
          reject_s = 1'b1;
        end else if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ORIG;
          cnt_nxt_s   = 4'd0;
          issue_s     = 1'b1;
          nrow_s      = blk_row;
          ncol_s      = blk_col;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ORIG: begin
        if (cnt_r != 4'd15) begin
          cnt_nxt_s = cnt_r + 4'd1;
          issue_s   = 1'b1;
          nrow_s    = row_r + {14'd0, cnt_nxt_s[3:2]};
          ncol_s    = col_r + {14'd0, cnt_nxt_s[1:0]};
          nslot_s   = {1'b0, cnt_nxt_s};
        end else if (top_avail) begin
          state_nxt_s = TOP;
          cnt_nxt_s   = 4'd0;
          issue_s     = 1'b1;
          nsel_s      = 1'b1;
          nrow_s      = row_r - 16'd1;
          nslot_s     = 5'd16;
        end else if (left_avail) begin
          state_nxt_s = LEFT;
          cnt_nxt_s   = 4'd0;
          issue_s     = 1'b1;
          nsel_s      = 1'b1;
          ncol_s      = col_r - 16'd1;
          nslot_s     = 5'd20;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      TOP: begin
        if (cnt_r != 4'd3) begin
          cnt_nxt_s = cnt_r + 4'd1;
          issue_s   = 1'b1;
          nsel_s    = 1'b1;
          nrow_s    = row_r - 16'd1;
          ncol_s    = col_r + {14'd0, cnt_nxt_s[1:0]};
          nslot_s   = {3'b100, cnt_nxt_s[1:0]};
        end else if (left_avail) begin
          state_nxt_s = LEFT;
          cnt_nxt_s   = 4'd0;
          issue_s     = 1'b1;
          nsel_s      = 1'b1;
          ncol_s      = col_r - 16'd1;
          nslot_s     = 5'd20;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      LEFT: begin
        if (cnt_r != 4'd3) begin
          cnt_nxt_s = cnt_r + 4'd1;
          issue_s   = 1'b1;
          nsel_s    = 1'b1;
          nrow_s    = row_r + {14'd0, cnt_nxt_s[1:0]};
          ncol_s    = col_r - 16'd1;
          nslot_s   = {3'b101, cnt_nxt_s[1:0]};
        end else if (top_avail) begin
          // corner is fetched only when both neighbours exist
          state_nxt_s = CORNER;
          issue_s     = 1'b1;
          nsel_s      = 1'b1;
          nrow_s      = row_r - 16'd1;
          ncol_s      = col_r - 16'd1;
          nslot_s     = 5'd24;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      CORNER: state_nxt_s = DRAIN;
      DRAIN:  state_nxt_s = OUT;
      OUT: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control registers, status outputs and the registered read port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      row_r      <= 16'd0;
      col_r      <= 16'd0;
      slot_r     <= 5'd0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      start_err  <= 1'b0;
      rd_en      <= 1'b0;
      rd_sel     <= 1'b0;
      rd_addr    <= '0;
      top_avail  <= 1'b0;
      left_avail <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      busy      <= (state_nxt_s != IDLE);
      out_valid <= (state_nxt_s == OUT);
      start_err <= reject_s;
      rd_en     <= issue_s;
      if (issue_s) begin
        rd_sel  <= nsel_s;
        rd_addr <= ADDR_W'(nrow_s) * ADDR_W'(WIDTH) + ADDR_W'(ncol_s);
        slot_r  <= nslot_s;
      end
      if (accept_s) begin
        row_r      <= blk_row;
        col_r      <= blk_col;
        top_avail  <= (blk_row != 16'd0);
        left_avail <= (blk_col != 16'd0);
      end
    end
  end

  // Return-data capture: the slot pointer lags the bus by one cycle to match memory latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_vld_r  <= 1'b0;
      cap_slot_r <= 5'd0;
      orig_blk   <= {16{FILL}};
      top_row    <= {4{FILL}};
      left_col   <= {4{FILL}};
      corner     <= FILL;
    end else begin
      cap_vld_r  <= rd_en;
      cap_slot_r <= slot_r;
      if (accept_s) begin
        // neighbours that will not be fetched must read as FILL
        top_row  <= {4{FILL}};
        left_col <= {4{FILL}};
        corner   <= FILL;
      end else if (cap_vld_r) begin
        case (cap_slot_r[4:2])
          3'b000, 3'b001, 3'b010, 3'b011: orig_blk[{cap_slot_r[3:0], 3'b000} +: 8] <= rd_data;
          3'b100:  top_row[{cap_slot_r[1:0], 3'b000} +: 8]  <= rd_data;
          3'b101:  left_col[{cap_slot_r[1:0], 3'b000} +: 8] <= rd_data;
          3'b110:  corner <= rd_data;
          default: corner <= corner;
        endcase
      end else begin
        corner <= corner;
      end
    end
  end

endmodule

// File: tb/tb_intra_block_fetch4x4.sv
module tb_intra_block_fetch4x4;
  localparam int W  = 32;
  localparam int L  = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [15:0]   blk_row = 16'd0, blk_col = 16'd0;
  logic [7:0]    rd_data;
  logic          busy, start_err, rd_en, rd_sel, out_valid, top_avail, left_avail;
  logic [AW-1:0] rd_addr;
  logic [127:0]  orig_blk;
  logic [31:0]   top_row, left_col;
  logic [7:0]    corner;

  intra_block_fetch4x4 #(.WIDTH(W), .LENGTH(L), .ADDR_W(AW), .FILL(8'd128)) dut (
    .clk(clk), .reset(rst_n), .start(start), .blk_row(blk_row), .blk_col(blk_col),
    .busy(busy), .start_err(start_err), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .orig_blk(orig_blk), .top_row(top_row), .left_col(left_col), .corner(corner),
    .top_avail(top_avail), .left_avail(left_avail)
  );

  always #5 clk = ~clk;

  // frame memories with one-cycle synchronous read
  logic [7:0] omem [0:1023];
  logic [7:0] rmem [0:1023];
  always @(posedge clk) if (rd_en) rd_data <= rd_sel ? rmem[rd_addr[9:0]] : omem[rd_addr[9:0]];

  int checks = 0, passes = 0, fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: expected bundle and read list from coordinates
  logic [127:0] e_orig;
  logic [31:0]  e_top, e_left;
  logic [7:0]   e_corner;
  logic         e_tav, e_lav;
  int           e_n;
  logic [16:0]  exp_rd [$];

  task automatic model(input int r, input int c);
    exp_rd.delete();
    e_tav = (r != 0);
    e_lav = (c != 0);
    e_top = {4{8'h80}}; e_left = {4{8'h80}}; e_corner = 8'h80;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        e_orig[(i*4+j)*8 +: 8] = omem[(r+i)*W + c + j];
        exp_rd.push_back({1'b0, 16'((r+i)*W + c + j)});
      end
    if (e_tav) for (int j = 0; j < 4; j++) begin
      e_top[j*8 +: 8] = rmem[(r-1)*W + c + j];
      exp_rd.push_back({1'b1, 16'((r-1)*W + c + j)});
    end
    if (e_lav) for (int i = 0; i < 4; i++) begin
      e_left[i*8 +: 8] = rmem[(r+i)*W + c - 1];
      exp_rd.push_back({1'b1, 16'((r+i)*W + c - 1)});
    end
    if (e_tav && e_lav) begin
      e_corner = rmem[(r-1)*W + c - 1];
      exp_rd.push_back({1'b1, 16'((r-1)*W + c - 1)});
    end
    e_n = exp_rd.size();
  endtask

  task automatic chk_payload(input string tag);
    chk({tag, "_orig"}, orig_blk, e_orig);
    chk({tag, "_top"}, top_row, e_top);
    chk({tag, "_left"}, left_col, e_left);
    chk({tag, "_corner"}, corner, e_corner);
    chk({tag, "_flags"}, {top_avail, left_avail}, {e_tav, e_lav});
  endtask

  task automatic run_block(input int r, input int c, input int hold);
    int cyc, nreads, mism, errs;
    logic [16:0] e;
    model(r, c);
    @(negedge clk); blk_row = 16'(r); blk_col = 16'(c); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; nreads = 0; mism = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (rd_en) begin
        nreads++;
        if (exp_rd.size() == 0) mism++;
        else begin
          e = exp_rd.pop_front();
          if ({rd_sel, 16'(rd_addr)} !== e) mism++;
        end
      end
      if (out_valid) break;
      cyc++;
    end
    chk("latency", cyc, e_n + 1);
    chk("nreads", nreads, e_n);
    chk("rd_seq", mism, 0);
    chk_payload("bundle");
    if (hold > 0) begin
      errs = 0;
      for (int k = 0; k < hold; k++) begin
        if (k == 1) begin blk_row = 16'd0; blk_col = 16'd30; start = 1'b1; end
        else start = 1'b0;
        @(negedge clk);
        if (start_err !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1 || rd_en !== 1'b0) errs++;
      end
      chk("hold_status", errs, 0);
      chk_payload("held");
      // start on the handshake edge must be ignored
      blk_row = 16'd0; blk_col = 16'd0; start = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); out_ready = 1'b0;
    chk("done_idle", {out_valid, busy, rd_en, start_err}, 4'b0000);
  endtask

  task automatic bad_start(input int r, input int c);
    @(negedge clk); blk_row = 16'(r); blk_col = 16'(c); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("bad_err_pulse", {start_err, busy, rd_en}, 3'b100);
    @(negedge clk);
    chk("bad_err_clear", {start_err, busy, rd_en}, 3'b000);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      omem[a] = 8'(a);
      rmem[a] = ~8'(a);
    end
    repeat (3) @(negedge clk);
    chk("rst_status", {busy, start_err, rd_en, out_valid, top_avail, left_avail}, 6'd0);
    chk("rst_orig", orig_blk, {16{8'h80}});
    chk("rst_nbr", {top_row, left_col, corner}, {{8{8'h80}}, 8'h80});
    rst_n = 1'b1;

    run_block(8, 12, 0);
    chk("int_orig00", orig_blk[7:0], 8'h0C);
    chk("int_top0", top_row[7:0], 8'h13);
    chk("int_left0", left_col[7:0], 8'hF4);
    chk("int_corner", corner, 8'h14);
    chk("int_nreads", e_n, 25);

    run_block(0, 0, 0);
    chk("org_nbr", {top_row, left_col, corner}, {32'h80808080, 32'h80808080, 8'h80});
    chk("org_flags", {top_avail, left_avail}, 2'b00);

    run_block(0, 16, 0);
    chk("edge_flags", {top_avail, left_avail}, 2'b01);
    chk("edge_left0", left_col[7:0], 8'hF0);
    chk("edge_top", top_row, 32'h80808080);

    run_block(8, 12, 10);
    run_block(4, 8, 0);

    bad_start(0, 30);
    bad_start(6, 0);

    // asynchronous reset during the TOP phase
    @(negedge clk); blk_row = 16'd8; blk_col = 16'd12; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre_rst_top", {rd_en, rd_sel, busy}, 3'b111);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {rd_en, busy, out_valid}, 3'b000);
    chk("async_rst_fill", top_row, 32'h80808080);
    @(negedge clk); rst_n = 1'b1;
    run_block(4, 4, 0);

    // random memory contents and positions
    for (int a = 0; a < 1024; a++) begin
      omem[a] = 8'($urandom);
      rmem[a] = 8'($urandom);
    end
    for (int t = 0; t < 8; t++)
      run_block(4 * $urandom_range(0, 7), 4 * $urandom_range(0, 7), $urandom_range(0, 3));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/intra_block_fetch4x4.md
Name: intra_block_fetch4x4

Overview:
- Upstream feeder for the intra-loop engines: on a start request for a 4x4 luma block position, reads the 16 original pixels plus the reconstructed top row, left column and top-left corner from frame memory over one shared synchronous read port.
- Emits one packed block/neighbour bundle with availability flags over a valid/ready handshake.
- Two instances, one per intra engine, are driven by the encoder's block scheduler.

Parameters:
- WIDTH, 32, frame width in pixels (multiple of 4)
- LENGTH, 32, frame height in pixels (multiple of 4)
- ADDR_W, 16, frame-memory address width; must be at least clog2(WIDTH*LENGTH)
- FILL, 8'd128, value substituted for unavailable neighbours

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request pulse; accepted only in IDLE
- blk_row  in  16  pixel row of block top-left; sampled with start
- blk_col  in  16  pixel column of block top-left; sampled with start
- busy  out  1  high whenever state is not IDLE
- start_err  out  1  one-cycle pulse when start is rejected for bad coordinates
- rd_en  out  1  memory read strobe
- rd_sel  out  1  0 = original frame, 1 = reconstructed frame
- rd_addr  out  ADDR_W  read address = r*WIDTH + c
- rd_data  in  8  read data, valid on the edge after the rd_en cycle
- out_valid  out  1  bundle valid
- out_ready  in  1  consumer accept
- orig_blk  out  128  original pixels; pixel (i,j) at bits [(i*4+j)*8 +: 8]
- top_row  out  32  recon pixels (blk_row-1, blk_col+j); j at [j*8 +: 8]
- left_col  out  32  recon pixels (blk_row+i, blk_col-1); i at [i*8 +: 8]
- corner  out  8  recon pixel (blk_row-1, blk_col-1)
- top_avail  out  1  blk_row != 0
- left_avail  out  1  blk_col != 0

Behaviour:
- Reset: async and active-low. All outputs 0 except that payload registers are set to FILL. State returns to IDLE. Applies mid-operation; the in-flight read is discarded.
- States: IDLE, ORIG, TOP, LEFT, CORNER, DRAIN, OUT.
- Start validation: start in IDLE with blk_row>LENGTH-4, blk_col>WIDTH-4, or either coordinate not a multiple of 4:
  - start_err pulses for one cycle;
  - state stays IDLE;
  - no reads are issued.
- Start while busy: ignored, no error.
- Valid start at edge E: coordinates and the availability flags are latched and the state moves to ORIG.
- Read sequence (rd_en high for one read per cycle, back to back, no gaps):
  - ORIG: 16 reads, rd_sel=0, raster order i then j.
  - TOP: 4 reads, j = 0..3. Skipped if top_avail=0.
  - LEFT: 4 reads, i = 0..3. Skipped if left_avail=0.
  - CORNER: 1 read. Only when both flags are 1.
  - rd_sel=1 in TOP, LEFT and CORNER.
- Read count: N = 16 + 4*top_avail + 4*left_avail + (top_avail & left_avail). N is 16, 20 or 25.
- Read timing: reads occupy the cycles following edges E..E+N-1.
- Capture: the data for each read is captured on the next edge into a slot-indexed register. A one-cycle-delayed slot pointer tracks which slot each returning word belongs to.
- DRAIN: one cycle after the last read, capturing the final word.
- out_valid: goes high after edge E+N+1, i.e. 17, 21 or 26 cycles after the accepting edge.
- Unavailable neighbour fields hold FILL; they are rewritten to FILL at every accepted start.
- OUT: the payload is held stable while out_valid=1 and out_ready=0.
  - The handshake completes on an edge with out_valid & out_ready; out_valid drops and the state returns to IDLE.
  - A start presented on that same edge is ignored, since the block is still busy. The earliest new start is the following cycle.
- Address arithmetic: computed at ADDR_W bits, no wrap. Valid coordinates guarantee the address stays below WIDTH*LENGTH.
- rd_addr and rd_sel hold their last values when rd_en=0.

Test Plan:
- Interior block, blk_row=8, blk_col=12, memory pattern orig[a]=a[7:0], recon[a]=~a[7:0]:
  - exactly 25 rd_en cycles; out_valid after 26 cycles;
  - orig_blk (0,0)=8'(8*32+12)=8'h0C;
  - top_row j=0 = ~8'(7*32+12);
  - left_col i=0 = ~8'(8*32+11);
  - corner = ~8'(7*32+11);
  - both avail flags 1.
- Block (0,0): 16 reads all with rd_sel=0; top_row=left_col=32'h80808080; corner=8'h80; both avail flags 0; out_valid after 17 cycles.
- Block (0,16): 20 reads; top_avail=0, left_avail=1; left_col from recon column 15; out_valid after 21 cycles.
- Backpressure: out_ready held 0 for 10 cycles after out_valid, with start pulsed meanwhile:
  - payload stable;
  - start ignored, no start_err;
  - after out_ready=1, IDLE next cycle;
  - a new start then proceeds normally.
- Bad coordinates: start with blk_col=30 (WIDTH=32), then blk_row=6: each gives a one-cycle start_err, busy stays 0, no rd_en.
- Reset assert (low) asynchronously during the TOP phase: rd_en, busy and out_valid go to 0 immediately. After release, a fresh start at (4,4) completes with correct data.
